alu_result_tx: RTL and testbench
================================

# alu_result_tx

Result-side transmitter for the ALU datapath. It takes one finished ALU result word plus status flags through a valid/ready handshake. It then sends the result off-chip as a framed byte stream on the 8-bit `uo_out` bus, using a strobe/acknowledge handshake with the external host. It sits between the ALU output and the top-level output pins, and is the counterpart of the operand path that feeds the ALU from `ui_in`.

## Interface

Parameters:
- `DATA_W`, 32, result width in bits; must be a multiple of 8 and at least 8.
- `TIMEOUT`, 255, cycles `tx_strb` may stay high without `tx_ack` before the frame aborts; range 1..65535.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `res_valid`  input  1  ALU result available.
- `res_ready`  output  1  block can accept a result.
- `res_data`  input  DATA_W  ALU result word.
- `res_flags`  input  4  ALU status flags {ovf, carry, neg, zero}.
- `tx_byte`  output  8  current frame byte (drives `uo_out`).
- `tx_strb`  output  1  `tx_byte` valid; held until acknowledged.
- `tx_ack`  input  1  host accepted the byte.
- `tx_busy`  output  1  a frame is in progress.
- `tx_err`  output  1  one-cycle pulse on timeout abort.

## Operation

Frame format, NB = DATA_W/8, NB+2 bytes total:
- Byte 0, header: {4'hA, flags}.
- Bytes 1..NB: `res_data`, most significant byte first.
- Byte NB+1: checksum, the XOR of bytes 0..NB.

Capture:
- A result is accepted when `res_valid && res_ready` on a clock edge.
- `res_data` and `res_flags` are registered at that edge. Later input changes do not affect the frame.

FSM states:
- IDLE: `res_ready=1`, `tx_strb=0`. On accept, go to SEND with byte index 0 and checksum accumulator 0.
- SEND: `tx_strb=1`, `tx_byte` = current byte.
  - If `tx_ack=1`: XOR the byte into the accumulator and clear the timeout counter.
  - After an ack on the last byte, go to IDLE. After an ack on any other byte, increment the index and go to GAP.
  - If there is no ack and the timeout counter equals TIMEOUT-1, go to IDLE and pulse `tx_err`. Otherwise increment the counter.
- GAP: `tx_strb=0` for exactly one cycle, then return to SEND.

Behaviour rules:
- `tx_ack` is ignored in IDLE and GAP.
- Ack and timeout on the same cycle: the ack wins and no error is raised.
- The checksum byte is computed from the accumulator, not stored.
- `tx_byte` is 8'h00 whenever `tx_strb=0`.
- `tx_busy` = (state != IDLE).
- `res_ready` = (state == IDLE). There is no buffering; a result offered mid-frame waits.
- `rst` asserted in any state: at the next edge go to IDLE with all counters cleared. The partial frame is dropped and `tx_err` is not pulsed.

## Timing

- Values after reset: `res_ready=1`, `tx_strb=0`, `tx_byte=8'h00`, `tx_busy=0`, `tx_err=0`.
- Accept at edge N: `tx_strb=1` with the header from cycle N+1.
- Ack sampled at edge M, not the last byte: `tx_strb=0` during cycle M+1, next byte with `tx_strb=1` from cycle M+2.
- Ack on the last byte at edge M: IDLE and `res_ready=1` from cycle M+1. A new accept at edge M+1 gives the new header at M+2.
- Minimum frame time, ack held high: 2·(NB+2)−1 cycles from the first strobe to the last ack. For DATA_W=32 this is 11 cycles.
- Timeout: with `tx_strb` first high in cycle S and no ack, the abort edge is S+TIMEOUT−1.
  - `tx_err=1` and `tx_strb=0` during cycle S+TIMEOUT.
  - IDLE and `res_ready=1` in the same cycle.
- The timeout counter restarts for each byte.

## Test plan

- Basic frame, DATA_W=32: `res_data`=0x3F800000, `res_flags`=4'h2, `tx_ack` held 1.
  - Required bytes A2,3F,80,00,00,1D, each strobed for one cycle with a one-cycle gap between.
  - `tx_busy` low and `res_ready` high the cycle after the 0x1D ack.
- Slow host: ack each byte 5 cycles after its strobe rises.
  - Each `tx_byte` stays stable while strobed.
  - Acks during a gap are ignored; no byte is duplicated or skipped.
- Back-pressure: hold `res_valid` with 0x12345678 throughout a frame for 0xDEADBEEF.
  - 0x12345678 is captured only in the cycle after the DEADBEEF checksum ack.
  - Second frame bytes: header, 12,34,56,78, checksum.
- Timeout, TIMEOUT=4: never ack.
  - `tx_strb` high for exactly 4 cycles, then `tx_err` pulses once.
  - FSM back in IDLE with `res_ready=1`; a following frame sends normally.
- Ack coincident with the timeout cycle: no `tx_err`, and the frame continues.
- Reset while strobing byte 2: next cycle all outputs at reset values with no `tx_err`; a new frame starts with the header byte.

Source files
------------

// File: rtl/alu_result_tx.sv
// alu_result_tx: frames one ALU result plus flags into a byte stream
// (header, MSB-first payload, XOR checksum) over a strobe/ack link.
module alu_result_tx #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  input  logic [3:0]        res_flags,
  output logic [7:0]        tx_byte,
  output logic              tx_strb,
  input  logic              tx_ack,
  output logic              tx_busy,
  output logic              tx_err
);

  localparam int NB = DATA_W / 8;
  localparam int IW = $clog2(NB + 2);
  localparam logic [IW-1:0] LAST = IW'(NB + 1);
  localparam logic [15:0] TLIM = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] sh_q;
  logic [3:0]        flags_q;
  logic [IW-1:0]     idx_q;
  logic [7:0]        acc_q;
  logic [15:0]       tcnt_q;
  logic              err_q;

  logic       accept;
  logic       ack_hit;
  logic       last;
  logic       tmo;
  logic [7:0] cur_byte;

  assign accept  = res_valid && (state_q == IDLE);
  assign ack_hit = (state_q == SEND) && tx_ack;
  assign last    = (idx_q == LAST);
  assign tmo     = (state_q == SEND) && !tx_ack
                   && (tcnt_q == TLIM);

  // Payload bytes come from the top of a left-shifting copy.
  always_comb begin
    cur_byte = sh_q[DATA_W-1 -: 8];
    unique case (1'b1)
      (idx_q == '0): cur_byte = {4'hA, flags_q};
      last:          cur_byte = acc_q;
      default:       cur_byte = sh_q[DATA_W-1 -: 8];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
        if (tx_ack) begin
          state_d = last ? IDLE : GAP;
        end else if (tmo) begin
          state_d = IDLE;
        end
      end
      GAP:     state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    res_ready = (state_q == IDLE);
    tx_strb   = (state_q == SEND);
    tx_busy   = (state_q != IDLE);
    tx_err    = err_q;
    tx_byte   = 8'h00;
    if (state_q == SEND) tx_byte = cur_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      flags_q <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= tmo;
      if (accept) begin
        sh_q    <= res_data;
        flags_q <= res_flags;
        idx_q   <= '0;
        acc_q   <= '0;
        tcnt_q  <= '0;
      end else if (ack_hit) begin
        acc_q  <= acc_q ^ cur_byte;
        tcnt_q <= '0;
        if (!last) idx_q <= idx_q + 1'b1;
        if ((idx_q != '0) && !last) sh_q <= sh_q << 8;
      end else if (state_q == SEND) begin
        tcnt_q <= tmo ? '0 : tcnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: frame-level model plus directed vectors for
// the ALU result transmitter, with a short-timeout second instance.
module tb_alu_result_tx;

  localparam int NB     = 4;
  localparam int T_MAIN = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        res_valid = 1'b0;
  logic [31:0] res_data  = '0;
  logic [3:0]  res_flags = '0;
  logic        tx_ack    = 1'b0;
  logic        res_ready, tx_strb, tx_busy, tx_err;
  logic [7:0]  tx_byte;

  logic        to_valid = 1'b0;
  logic [31:0] to_data  = '0;
  logic [3:0]  to_flags = '0;
  logic        to_ack   = 1'b0;
  logic        to_ready, to_strb, to_busy, to_err;
  logic [7:0]  to_byte;

  int n_chk  = 0;
  int n_fail = 0;
  int to_err_cnt = 0;

  logic [7:0] log_m[$];
  logic [7:0] log_t[$];

  always #5 clk = ~clk;

  alu_result_tx u_dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags),
    .tx_byte(tx_byte), .tx_strb(tx_strb), .tx_ack(tx_ack),
    .tx_busy(tx_busy), .tx_err(tx_err)
  );

  alu_result_tx #(.DATA_W(32), .TIMEOUT(4)) u_to (
    .clk(clk), .rst(rst),
    .res_valid(to_valid), .res_ready(to_ready),
    .res_data(to_data), .res_flags(to_flags),
    .tx_byte(to_byte), .tx_strb(to_strb), .tx_ack(to_ack),
    .tx_busy(to_busy), .tx_err(to_err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Whole frame as transmitted: byte k at bits [8k+:8].
  function automatic logic [47:0] frame_of(input logic [31:0] d,
                                           input logic [3:0] f);
    logic [47:0] r;
    logic [7:0]  cs;
    r = '0;
    r[7:0] = {4'hA, f};
    cs = r[7:0];
    for (int k = 1; k <= NB; k++) begin
      r[8*k +: 8] = d[8*(NB-k) +: 8];
      cs = cs ^ r[8*k +: 8];
    end
    r[47:40] = cs;
    return r;
  endfunction

  logic [47:0] m_fr;
  logic        m_act, m_gap, m_err;
  int          m_pos, m_wait;

  always @(posedge clk) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_gap  <= 1'b0;
      m_err  <= 1'b0;
      m_pos  <= 0;
      m_wait <= 0;
    end else begin
      m_err <= 1'b0;
      if (!m_act) begin
        if (res_valid) begin
          m_fr   <= frame_of(res_data, res_flags);
          m_act  <= 1'b1;
          m_gap  <= 1'b0;
          m_pos  <= 0;
          m_wait <= 0;
        end
      end else if (m_gap) begin
        m_gap <= 1'b0;
      end else if (tx_ack) begin
        m_wait <= 0;
        if (m_pos == NB + 1) begin
          m_act <= 1'b0;
        end else begin
          m_pos <= m_pos + 1;
          m_gap <= 1'b1;
        end
      end else if (m_wait == T_MAIN - 1) begin
        m_act <= 1'b0;
        m_err <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  always @(posedge clk) begin
    logic       e_strb;
    logic [7:0] e_byte;
    #1;
    e_strb = m_act && !m_gap;
    e_byte = e_strb ? m_fr[8*m_pos +: 8] : 8'h00;
    chk("cyc_ready", {31'd0, res_ready}, {31'd0, !m_act});
    chk("cyc_strb", {31'd0, tx_strb}, {31'd0, e_strb});
    chk("cyc_byte", {24'd0, tx_byte}, {24'd0, e_byte});
    chk("cyc_busy", {31'd0, tx_busy}, {31'd0, m_act});
    chk("cyc_err", {31'd0, tx_err}, {31'd0, m_err});
  end

  always @(negedge clk) begin
    #1;
    if (!rst && tx_strb && tx_ack) log_m.push_back(tx_byte);
    if (!rst && to_strb && to_ack) log_t.push_back(to_byte);
    if (to_err) to_err_cnt++;
  end

  task automatic check_log(input int sel, input int off,
                           input logic [47:0] e);
    logic [7:0] got;
    for (int k = 0; k < 6; k++) begin
      got = 8'hxx;
      if (sel == 0 && off + k < log_m.size()) got = log_m[off+k];
      if (sel == 1 && off + k < log_t.size()) got = log_t[off+k];
      chk($sformatf("log%0d_byte%0d", sel, off + k),
          {24'd0, got}, {24'd0, e[8*(5-k) +: 8]});
    end
  endtask

  task automatic wait_idle(input int sel, input int budget);
    int i;
    i = 0;
    while ((sel == 0 ? tx_busy : to_busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("wait_idle", {31'd0, (sel == 0 ? tx_busy : to_busy)}, 32'd0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_ready"}, {31'd0, res_ready}, 32'd1);
    chk({tag, "_strb"}, {31'd0, tx_strb}, 32'd0);
    chk({tag, "_byte"}, {24'd0, tx_byte}, 32'd0);
    chk({tag, "_busy"}, {31'd0, tx_busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, tx_err}, 32'd0);
  endtask

  initial begin
    int c, s_n, e_n, err0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_vals("rst");
    rst = 1'b0;

    // Basic frame, ack held high.
    log_m.delete();
    res_valid = 1'b1;
    res_data  = 32'h3F80_0000;
    res_flags = 4'h2;
    tx_ack    = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("basic_hdr_now", {24'd0, tx_byte}, 32'hA2);
    wait_idle(0, 40);
    chk("basic_ready", {31'd0, res_ready}, 32'd1);
    chk("basic_len", log_m.size(), 32'd6);
    check_log(0, 0, 48'hA2_3F_80_00_00_1D);

    // Slow host: ack 5 cycles into each strobe, ack also in gaps.
    log_m.delete();
    tx_ack    = 1'b0;
    res_valid = 1'b1;
    res_data  = 32'hCAFE_0001;
    res_flags = 4'h9;
    @(negedge clk);
    res_valid = 1'b0;
    c = 0;
    for (int i = 0; i < 200 && tx_busy; i++) begin
      if (tx_strb) begin
        c++;
        tx_ack = (c == 5);
      end else begin
        c = 0;
        tx_ack = 1'b1;
      end
      @(negedge clk);
    end
    tx_ack = 1'b0;
    chk("slow_idle", {31'd0, tx_busy}, 32'd0);
    chk("slow_len", log_m.size(), 32'd6);
    check_log(0, 0, 48'hA9_CA_FE_00_01_9C);

    // Back-pressure: second result waits for the whole first frame.
    log_m.delete();
    tx_ack    = 1'b1;
    res_valid = 1'b1;
    res_data  = 32'hDEAD_BEEF;
    res_flags = 4'h0;
    @(negedge clk);
    res_data = 32'h1234_5678;
    wait_idle(0, 40);
    chk("bp_ready", {31'd0, res_ready}, 32'd1);
    chk("bp_first_len", log_m.size(), 32'd6);
    @(negedge clk);
    res_valid = 1'b0;
    chk("bp_busy2", {31'd0, tx_busy}, 32'd1);
    wait_idle(0, 40);
    chk("bp_len", log_m.size(), 32'd12);
    check_log(0, 0, 48'hA0_DE_AD_BE_EF_82);
    check_log(0, 6, 48'hA0_12_34_56_78_A8);

    // Reset while strobing byte 2.
    tx_ack    = 1'b1;
    res_valid = 1'b1;
    res_data  = 32'h55AA_55AA;
    res_flags = 4'h3;
    @(negedge clk);
    res_valid = 1'b0;
    c = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx_strb) c++;
      if (tx_strb && c == 3) break;
      @(negedge clk);
    end
    chk("rst_reach", c, 32'd3);
    chk("rst_byte2", {24'd0, tx_byte}, 32'hAA);
    rst = 1'b1;
    @(negedge clk);
    reset_vals("midrst");
    rst = 1'b0;
    log_m.delete();
    res_valid = 1'b1;
    res_data  = 32'h0000_FF00;
    res_flags = 4'h4;
    @(negedge clk);
    res_valid = 1'b0;
    chk("post_rst_hdr", {24'd0, tx_byte}, 32'hA4);
    wait_idle(0, 40);
    chk("post_rst_len", log_m.size(), 32'd6);
    check_log(0, 0, 48'hA4_00_00_FF_00_5B);
    tx_ack = 1'b0;

    // Timeout instance: never ack.
    to_ack   = 1'b0;
    to_valid = 1'b1;
    to_data  = 32'hAAAA_AAAA;
    to_flags = 4'h0;
    @(negedge clk);
    to_valid = 1'b0;
    s_n = 0;
    e_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (to_strb) s_n++;
      if (to_err) begin
        e_n++;
        chk("to_err_strb", {31'd0, to_strb}, 32'd0);
        chk("to_err_ready", {31'd0, to_ready}, 32'd1);
        chk("to_err_busy", {31'd0, to_busy}, 32'd0);
      end
      @(negedge clk);
    end
    chk("to_strb_cycles", s_n, 32'd4);
    chk("to_err_pulses", e_n, 32'd1);

    // Normal frame after the abort.
    log_t.delete();
    err0     = to_err_cnt;
    to_ack   = 1'b1;
    to_valid = 1'b1;
    to_data  = 32'h0102_0304;
    to_flags = 4'h1;
    @(negedge clk);
    to_valid = 1'b0;
    wait_idle(1, 40);
    chk("to_after_len", log_t.size(), 32'd6);
    check_log(1, 0, 48'hA1_01_02_03_04_A5);
    chk("to_after_noerr", to_err_cnt - err0, 32'd0);

    // Ack on the very cycle the counter expires.
    log_t.delete();
    err0     = to_err_cnt;
    to_ack   = 1'b0;
    to_valid = 1'b1;
    to_data  = 32'h1122_3344;
    to_flags = 4'h0;
    @(negedge clk);
    to_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      to_ack = (k == 3);
      @(negedge clk);
    end
    to_ack = 1'b0;
    chk("co_err", {31'd0, to_err}, 32'd0);
    chk("co_gap_strb", {31'd0, to_strb}, 32'd0);
    chk("co_gap_busy", {31'd0, to_busy}, 32'd1);
    @(negedge clk);
    chk("co_next_strb", {31'd0, to_strb}, 32'd1);
    chk("co_next_byte", {24'd0, to_byte}, 32'h11);
    to_ack = 1'b1;
    wait_idle(1, 40);
    to_ack = 1'b0;
    chk("co_len", log_t.size(), 32'd6);
    check_log(1, 0, 48'hA0_11_22_33_44_E4);
    chk("co_noerr", to_err_cnt - err0, 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
